// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter/sequencer for the shared memory-address port.
// Grants one of four requesters, holds the mux select for MEM_LAT cycles, then pulses done.
module mem_access_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] w_req,
    input  logic [3:0] w_wr,
    output logic [1:0] flagIorD,
    output logic       flagMemWr,
    output logic [3:0] w_grant,
    output logic [3:0] w_done,
    output logic       w_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic       memwr_q, memwr_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] done_q, done_d;
    logic       busy_q, busy_d;

    logic [1:0] win;
    logic [1:0] cand;
    logic       found;

    // Search starts one past the previous winner; offset 4 wraps back to last_q itself.
    always_comb begin
        win   = last_q;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && w_req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        memwr_d = 1'b0;
        grant_d = grant_q;
        done_d  = 4'b0000;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = ACCESS;
                    sel_d   = win;
                    grant_d = 4'b0001 << win;
                    memwr_d = w_wr[win];
                    cnt_d   = LAT;
                    busy_d  = 1'b1;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                last_d  = sel_q;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    // memwr_q doubles as the latched write intent: it is only ever high in the first ACCESS cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            memwr_q <= 1'b0;
            grant_q <= 4'b0000;
            done_q  <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            memwr_q <= memwr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign flagIorD  = sel_q;
    assign flagMemWr = memwr_q;
    assign w_grant   = grant_q;
    assign w_done    = done_q;
    assign w_busy    = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: two instances (MEM_LAT=2 and 4) share the inputs.
module tb_mem_access_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] w_req;
    logic [3:0] w_wr;

    logic [1:0] f2, f4;
    logic       m2, m4;
    logic [3:0] g2, g4, d2, d4;
    logic       b2, b4;

    int vecs = 0;
    int errs = 0;

    mem_access_arbiter #(.MEM_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .w_req(w_req), .w_wr(w_wr),
        .flagIorD(f2), .flagMemWr(m2), .w_grant(g2), .w_done(d2), .w_busy(b2)
    );

    mem_access_arbiter #(.MEM_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .w_req(w_req), .w_wr(w_wr),
        .flagIorD(f4), .flagMemWr(m4), .w_grant(g4), .w_done(d4), .w_busy(b4)
    );

    always #5 clk = ~clk;

    // Packed view {busy, memwr, done, grant, sel}
    function automatic logic [11:0] ev(input logic b, input logic m, input logic [3:0] d,
                                       input logic [3:0] g, input logic [1:0] s);
        return {b, m, d, g, s};
    endfunction

    task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %03h expected %03h ({busy,wr,done,grant,sel})", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        w_req = 4'b0000;
        w_wr  = 4'b0000;
        step();
        step();
        chk("reset2", {b2, m2, d2, g2, f2}, 12'h000);
        chk("reset4", {b4, m4, d4, g4, f4}, 12'h000);
        reset = 1'b1;
        step();

        // Single read from source 0
        w_req = 4'b0001;
        step();
        chk("rd_c1", {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0000, 4'b0001, 2'd0));
        step();
        chk("rd_c2", {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0000, 4'b0001, 2'd0));
        step();
        chk("rd_c3", {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0001, 4'b0001, 2'd0));
        w_req = 4'b0000;
        step();
        chk("rd_idle", {b2, m2, d2, g2, f2}, ev(0, 0, 4'b0000, 4'b0000, 2'd0));

        // Write from source 1
        w_req = 4'b0010;
        w_wr  = 4'b0010;
        step();
        chk("wr_c1", {b2, m2, d2, g2, f2}, ev(1, 1, 4'b0000, 4'b0010, 2'd1));
        w_wr = 4'b0000;
        step();
        chk("wr_c2", {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0000, 4'b0010, 2'd1));
        step();
        chk("wr_c3", {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0010, 4'b0010, 2'd1));
        w_req = 4'b0000;
        step();
        chk("wr_idle", {b2, m2, d2, g2, f2}, ev(0, 0, 4'b0000, 4'b0000, 2'd1));

        // last=1, so all-request arbitration picks source 2; then async reset mid-access
        w_req = 4'b1111;
        step();
        chk("rr_after1", {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0000, 4'b0100, 2'd2));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst", {b2, m2, d2, g2, f2}, 12'h000);
        step();
        step();
        chk("rst_hold", {b2, m2, d2, g2, f2}, 12'h000);
        reset = 1'b1;

        // Round-robin with all four held: 0001,0010,0100,1000,0001 and one-cycle IDLE gaps
        for (int i = 0; i < 5; i++) begin
            logic [3:0] oh;
            logic [1:0] s;
            s  = 2'(i);
            oh = 4'b0001 << s;
            step();
            chk($sformatf("rr%0d_c1", i), {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0000, oh, s));
            if (i == 4) w_req = 4'b0000;
            step();
            chk($sformatf("rr%0d_c2", i), {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0000, oh, s));
            step();
            chk($sformatf("rr%0d_done", i), {b2, m2, d2, g2, f2}, ev(1, 0, oh, oh, s));
            step();
            chk($sformatf("rr%0d_idle", i), {b2, m2, d2, g2, f2}, ev(0, 0, 4'b0000, 4'b0000, s));
        end

        // Request withdrawn after one cycle still completes
        w_req = 4'b0100;
        step();
        chk("wd_c1", {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0000, 4'b0100, 2'd2));
        w_req = 4'b0000;
        step();
        chk("wd_c2", {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0000, 4'b0100, 2'd2));
        step();
        chk("wd_done", {b2, m2, d2, g2, f2}, ev(1, 0, 4'b0100, 4'b0100, 2'd2));
        step();
        chk("wd_idle", {b2, m2, d2, g2, f2}, ev(0, 0, 4'b0000, 4'b0000, 2'd2));

        // MEM_LAT=4: reset mid-ACCESS, no done pulse, then pending 1000 granted
        reset = 1'b0;
        step();
        reset = 1'b1;
        w_req = 4'b0001;
        step();
        chk("l4_c1", {b4, m4, d4, g4, f4}, ev(1, 0, 4'b0000, 4'b0001, 2'd0));
        w_req = 4'b1000;
        step();
        chk("l4_c2", {b4, m4, d4, g4, f4}, ev(1, 0, 4'b0000, 4'b0001, 2'd0));
        #2;
        reset = 1'b0;
        #1;
        chk("l4_async", {b4, m4, d4, g4, f4}, 12'h000);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("l4_rst%0d", i), {b4, m4, d4, g4, f4}, 12'h000);
        end
        reset = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk($sformatf("l4_g_c%0d", c), {b4, m4, d4, g4, f4},
                ev(1, 0, (c == 5) ? 4'b1000 : 4'b0000, 4'b1000, 2'd3));
            if (c == 5) w_req = 4'b0000;
        end
        step();
        chk("l4_idle", {b4, m4, d4, g4, f4}, ev(0, 0, 4'b0000, 4'b0000, 2'd3));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequencer and arbiter for the shared memory-address port of the multicycle datapath. Up to four requesters (PC fetch, data address, exception vector, auxiliary) compete for the single memory port. The block grants one at a time and drives the 2-bit `flagIorD` select of the memory-address multiplexer. It also issues the memory write strobe, holds the selection for the full memory latency, and signals completion to the winning requester.

## Interface
Parameters:
- `MEM_LAT`, default 2: memory access latency in cycles, legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; `reset`=0 immediately forces the reset state.
- `w_req`  in  4  request per source; bit i selects multiplexer input i (0=PC, 1=ALUOut, 2=exception vector, 3=aux).
- `w_wr`  in  4  write intent per source; sampled only with the grant.
- `flagIorD`  out  2  multiplexer select, equal to the index of the current or most recent grant.
- `flagMemWr`  out  1  memory write enable.
- `w_grant`  out  4  one-hot grant, held for the whole access.
- `w_done`  out  4  one-hot single-cycle completion pulse.
- `w_busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ACCESS, DONE. All outputs are registered.
- **IDLE**
  - If `w_req` is nonzero at the edge: select the winner by round-robin.
  - Search order starts at `last`+1 mod 4, where `last` is a 2-bit register holding the previous winner.
  - On that edge: `flagIorD` ← winner, `w_grant` ← one-hot(winner), `wr_lat` ← `w_wr[winner]`, `cnt` ← `MEM_LAT`, state → ACCESS.
  - If `w_req` is zero: stay in IDLE; `flagIorD` holds its last value.
- **ACCESS**
  - `flagMemWr` = `wr_lat` only in the first ACCESS cycle; otherwise 0.
  - `cnt` decrements each edge. At the edge where `cnt`==1: state → DONE and `w_done` ← one-hot(winner).
- **DONE**
  - `w_done` is high for exactly this one cycle. `w_grant` and `flagIorD` are unchanged.
  - At the next edge: state → IDLE, `w_grant` ← 0, `w_done` ← 0, `last` ← winner.
  - DONE always returns to IDLE; there is no direct DONE→ACCESS path.
- **Request rules**
  - A requester holds `w_req` until it sees its `w_done`.
  - Dropping `w_req` during ACCESS or DONE does not abort the access. It completes and `w_done` still pulses.
  - `w_req` and `w_wr` changes after the grant are ignored until the block is back in IDLE.
  - A request still high in the IDLE cycle after DONE is a new request and is arbitrated normally.
- **Simultaneous requests:** only one grant per arbitration. Non-winners wait with no loss of request.
- **Reset state** (also on mid-operation assertion)
  - State IDLE; `flagIorD`=00, `flagMemWr`=0, `w_grant`=0000, `w_done`=0000, `w_busy`=0.
  - `last`=3, so the first priority goes to source 0.
  - `cnt`=0, `wr_lat`=0.
  - No `w_done` pulse is produced for an aborted access.

## Timing
- Request sampled at edge k (IDLE): grant and select valid from k+1 for `MEM_LAT`+1 cycles.
- `flagMemWr` is high in cycle k+1 only.
- `w_done` is high in cycle k+1+`MEM_LAT`.
- Back in IDLE at k+2+`MEM_LAT`.
- Total occupancy is `MEM_LAT`+2 cycles per access, including the IDLE arbitration cycle.
- `w_busy` is high from k+1 through k+1+`MEM_LAT`.
- `flagIorD` is stable for the whole grant window. Memory read data is valid in the DONE cycle.
- Fairness: with all four requests held continuously, each source waits at most 3 accesses (3·(`MEM_LAT`+2) cycles) between grants.

## Test plan
- Reset: assert `reset`=0 mid-run → all outputs read 0 within the same cycle (async). After release, `req`=1111 → first grant is 0001.
- Single read, `MEM_LAT`=2: `w_req`=0001 at edge 0 → `w_grant`=0001 and `flagIorD`=00 in cycles 1–3; `w_done`=0001 in cycle 3 only; `flagMemWr`=0 throughout; `w_busy` high in cycles 1–3.
- Write from source 1: `w_req`=0010, `w_wr`=0010 → `flagIorD`=01; `flagMemWr`=1 only in the first grant cycle; `w_done`=0010 after `MEM_LAT`+1 cycles.
- Round-robin: `w_req`=1111 held continuously → grant sequence 0001, 0010, 0100, 1000, 0001, with IDLE gaps of exactly one cycle.
- Request withdrawn: `w_req`=0100 for 1 cycle, then 0000 → access still completes; `w_done`=0100 pulses; `flagIorD`=10 is held through DONE.
- Reset mid-ACCESS with `MEM_LAT`=4 → no `w_done` pulse. After release, a pending `w_req`=1000 is granted normally with full `MEM_LAT`.
